rr_mux_arbiter4: RTL and testbench
==================================

Name: rr_mux_arbiter4

Overview:
- Round-robin arbiter sharing one WIDTH-bit channel between four requesters.
- Registers a grant, steers the granted requester's data onto the shared output through an internal 4:1 mux, and enforces an optional hold limit.
- Sits in front of any single-consumer resource built from the 4:1 mux primitives.

Parameters:
WIDTH, 8, data width per requester and of the shared output
HOLD_MAX, 16, max consecutive GRANT cycles per tenure; 0 = unlimited; legal range 0..255

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
req  input  4  request per requester; bit i = requester i
data0  input  WIDTH  requester 0 data
data1  input  WIDTH  requester 1 data
data2  input  WIDTH  requester 2 data
data3  input  WIDTH  requester 3 data
grant  output  4  one-hot registered grant; all zero when idle
sel  output  2  registered index of the current or last grantee
busy  output  1  high while in GRANT
out_valid  output  1  busy & req[sel]; combinational from registered state
out_data  output  WIDTH  data[sel] when out_valid, else all zero
timeout  output  1  one-cycle pulse in the cycle after a hold-limit release

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (sampled at a rising clk edge): state=IDLE, grant=0000, sel=00, busy=0, timeout=0, ptr=0, hold_cnt=0.
  - Consequently out_valid=0 and out_data=0.
  - Reset mid-tenure drops grant at that edge. Reset has priority over every other event.
- Arbitration order: search req starting at index ptr, ascending, wrapping 3->0. The first set bit wins.
- IDLE:
  - If req != 0, the winner w is registered at the edge: grant=1<<w, sel=w, busy=1, hold_cnt=0, state=GRANT.
  - Latency is 1 cycle from req to grant.
  - If req == 0, state stays IDLE.
- GRANT (hold_cnt increments each cycle, saturating at 255):
  - Normal release: req[sel]=0 at an edge. Next state IDLE, grant=0000, busy=0, ptr=sel+1 mod 4.
  - Timeout release: HOLD_MAX!=0, hold_cnt==HOLD_MAX-1, and req[sel] still 1. Same transition as normal release, and timeout=1 for exactly the following cycle.
  - Simultaneous release conditions: if req[sel] drops on the same edge the limit is hit, it counts as a normal release and timeout stays 0.
  - Changes on other req bits during GRANT are ignored; there is no preemption.
- Every release passes through exactly one IDLE cycle. This bubble is mandatory, so back-to-back grants are never adjacent.
- A requester released by timeout that keeps req high is regranted only when no other requester wins under the advanced ptr. If it is alone, it is regranted after the single IDLE cycle.
- sel holds its last value in IDLE. Only out_valid and out_data qualify the data path.
- There are no combinational paths from req/data to grant or sel.
  - out_valid depends combinationally on req[sel].
  - out_data depends combinationally on data inputs and sel.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=0, ST_GRANT=1), NUM_REQ=4, HOLD_CNT_W=8.
- One sub-module: rr_pick4. It is combinational and maps req[3:0] plus ptr[1:0] to winner[1:0] and any_req.
- The output steering reuses the existing 4:1 mux primitive, instantiated per bit or WIDTH-wide.

Test Plan:
- Reset then req=0000 for 5 cycles -> grant=0000, busy=0, out_valid=0, out_data=0 throughout.
- From reset, req=1111 held, each requester dropping its req 3 cycles after its grant -> grants issued in order 0001,0010,0100,1000,0001, with one IDLE cycle between tenures.
- req=0100 alone with data2=8'hA5 -> grant=0100 one cycle later, sel=2, out_valid=1, out_data=A5. Then drop req[2] -> next cycle busy=0, out_data=00.
- HOLD_MAX=4, req=0011 held forever -> requester 0 granted 4 cycles, timeout=1 in the following IDLE cycle, then requester 1 granted 4 cycles, then requester 0 again.
- req[1] drops on the same edge that hold_cnt==HOLD_MAX-1 -> normal release, timeout stays 0.
- reset asserted on the 2nd GRANT cycle with req=1000 held -> next cycle grant=0000, ptr=0. After reset deasserts, requester 3 is granted one cycle later.

Source files
------------

// File: rtl/rr_mux_arbiter4_pkg.sv
// Shared types and constants for the four-way round-robin channel arbiter.
package rr_mux_arbiter4_pkg;

    localparam int NUM_REQ    = 4;
    localparam int HOLD_CNT_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/mux4.sv
// Generic W-bit 4:1 mux primitive.
// Purely combinational, no backpressure.
module mux4 #(
    parameter int W = 8
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [W-1:0] y
);

    always_comb begin
        y = d0;
        case (sel)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            2'd3: y = d3;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter4_pick4.sv
// Rotating priority picker: first set req bit at or above ptr, wrapping 3->0.
// Purely combinational, no backpressure.
module rr_pick4
    import rr_mux_arbiter4_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [1:0]         winner,
    output logic               any_req
);

    logic       found;
    logic [1:0] idx;

    always_comb begin
        winner  = ptr;
        any_req = |req;
        found   = 1'b0;
        idx     = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter4.sv
// Round-robin arbiter steering one of four requesters onto a shared channel.
// Grant 1 cycle after req; one IDLE bubble per release; no preemption, optional hold limit.
module rr_mux_arbiter4
    import rr_mux_arbiter4_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [WIDTH-1:0] data3,
    output logic [3:0]       grant,
    output logic [1:0]       sel,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             timeout
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_MAX - 1);
    localparam logic [HOLD_CNT_W-1:0] HOLD_SAT  = {HOLD_CNT_W{1'b1}};

    state_e                state_q, state_d;
    logic [3:0]            grant_q, grant_d;
    logic [1:0]            sel_q, sel_d;
    logic [1:0]            ptr_q, ptr_d;
    logic                  timeout_q, timeout_d;
    logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [1:0]            winner;
    logic                  any_req;
    logic                  limit_hit;
    logic [WIDTH-1:0]      mux_dat;

    rr_pick4 u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    assign limit_hit = (HOLD_MAX != 0) && (hold_cnt_q == HOLD_LAST);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d    = ST_GRANT;
                    grant_d    = 4'b0001 << winner;
                    sel_d      = winner;
                    hold_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                hold_cnt_d = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q : hold_cnt_q + 1'b1;
                if (!req[sel_q] || limit_hit) begin
                    state_d   = ST_IDLE;
                    grant_d   = 4'b0000;
                    ptr_d     = sel_q + 2'd1;
                    // A dropped request wins over the limit, so only flag a still-held one.
                    timeout_d = req[sel_q];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= 4'b0000;
            sel_q      <= 2'd0;
            ptr_q      <= 2'd0;
            timeout_q  <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            timeout_q  <= timeout_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    mux4 #(.W(WIDTH)) u_mux (
        .sel (sel_q),
        .d0  (data0),
        .d1  (data1),
        .d2  (data2),
        .d3  (data3),
        .y   (mux_dat)
    );

    assign grant     = grant_q;
    assign sel       = sel_q;
    assign busy      = (state_q == ST_GRANT);
    assign timeout   = timeout_q;
    assign out_valid = busy & req[sel_q];
    assign out_data  = out_valid ? mux_dat : '0;

endmodule

// File: tb/tb_rr_mux_arbiter4.sv
// Directed-vector bench for rr_mux_arbiter4 (HOLD_MAX=4) with a queue-based scoreboard.
module tb_rr_mux_arbiter4;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
        logic       vld;
        logic [7:0] dat;
        logic       tmo;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [7:0] data0, data1, data2, data3;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy, out_valid, timeout;
    logic [7:0] out_data;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    rr_mux_arbiter4 #(.WIDTH(8), .HOLD_MAX(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .data3     (data3),
        .grant     (grant),
        .sel       (sel),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .timeout   (timeout)
    );

    task automatic v(input logic rst, input logic [3:0] rq, input logic [3:0] g,
                     input logic [1:0] s, input logic b, input logic vl,
                     input logic [7:0] d, input logic t, input int n);
        vec_t e;
        e.rst = rst; e.req = rq; e.grant = g; e.sel = s;
        e.busy = b; e.vld = vl; e.dat = d; e.tmo = t;
        for (int i = 0; i < n; i++) vecs.push_back(e);
    endtask

    task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, expv);
        end
    endtask

    // Monitor: every sampled cycle is one DUT output beat to check against the queue.
    initial begin : monitor
        int row = 0;
        vec_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("grant",     row, {4'h0, grant},   {4'h0, e.grant});
                chk("sel",       row, {6'h0, sel},     {6'h0, e.sel});
                chk("busy",      row, {7'h0, busy},    {7'h0, e.busy});
                chk("out_valid", row, {7'h0, out_valid}, {7'h0, e.vld});
                chk("out_data",  row, out_data,        e.dat);
                chk("timeout",   row, {7'h0, timeout}, {7'h0, e.tmo});
                row++;
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1;
        req   = 4'b0000;
        data0 = 8'h10; data1 = 8'h21; data2 = 8'hA5; data3 = 8'h3C;

        // Reset and idle.
        v(1, 4'b0000, 4'b0000, 0, 0, 0, 8'h00, 0, 1);
        v(0, 4'b0000, 4'b0000, 0, 0, 0, 8'h00, 0, 5);
        // Lone requester 2.
        v(0, 4'b0100, 4'b0000, 0, 0, 0, 8'h00, 0, 1);
        v(0, 4'b0100, 4'b0100, 2, 1, 1, 8'hA5, 0, 1);
        v(0, 4'b0000, 4'b0100, 2, 1, 0, 8'h00, 0, 1);
        v(0, 4'b0000, 4'b0000, 2, 0, 0, 8'h00, 0, 1);
        // All four requesting, each releasing after three grant cycles.
        v(1, 4'b0000, 4'b0000, 2, 0, 0, 8'h00, 0, 1);
        v(0, 4'b1111, 4'b0000, 0, 0, 0, 8'h00, 0, 1);
        v(0, 4'b1111, 4'b0001, 0, 1, 1, 8'h10, 0, 2);
        v(0, 4'b1110, 4'b0001, 0, 1, 0, 8'h00, 0, 1);
        v(0, 4'b1111, 4'b0000, 0, 0, 0, 8'h00, 0, 1);
        v(0, 4'b1111, 4'b0010, 1, 1, 1, 8'h21, 0, 2);
        v(0, 4'b1101, 4'b0010, 1, 1, 0, 8'h00, 0, 1);
        v(0, 4'b1111, 4'b0000, 1, 0, 0, 8'h00, 0, 1);
        v(0, 4'b1111, 4'b0100, 2, 1, 1, 8'hA5, 0, 2);
        v(0, 4'b1011, 4'b0100, 2, 1, 0, 8'h00, 0, 1);
        v(0, 4'b1111, 4'b0000, 2, 0, 0, 8'h00, 0, 1);
        v(0, 4'b1111, 4'b1000, 3, 1, 1, 8'h3C, 0, 2);
        v(0, 4'b0111, 4'b1000, 3, 1, 0, 8'h00, 0, 1);
        v(0, 4'b1111, 4'b0000, 3, 0, 0, 8'h00, 0, 1);
        v(0, 4'b0000, 4'b0001, 0, 1, 0, 8'h00, 0, 1);
        v(0, 4'b0000, 4'b0000, 0, 0, 0, 8'h00, 0, 1);
        // Hold-limit releases with req=0011 held.
        v(1, 4'b0000, 4'b0000, 0, 0, 0, 8'h00, 0, 1);
        v(0, 4'b0011, 4'b0000, 0, 0, 0, 8'h00, 0, 1);
        v(0, 4'b0011, 4'b0001, 0, 1, 1, 8'h10, 0, 4);
        v(0, 4'b0011, 4'b0000, 0, 0, 0, 8'h00, 1, 1);
        v(0, 4'b0011, 4'b0010, 1, 1, 1, 8'h21, 0, 4);
        v(0, 4'b0011, 4'b0000, 1, 0, 0, 8'h00, 1, 1);
        // Requester 1 drops exactly when the limit is reached: no timeout.
        v(0, 4'b0010, 4'b0001, 0, 1, 0, 8'h00, 0, 1);
        v(0, 4'b0010, 4'b0000, 0, 0, 0, 8'h00, 0, 1);
        v(0, 4'b0010, 4'b0010, 1, 1, 1, 8'h21, 0, 3);
        v(0, 4'b0000, 4'b0010, 1, 1, 0, 8'h00, 0, 1);
        v(0, 4'b0000, 4'b0000, 1, 0, 0, 8'h00, 0, 2);
        // Reset on the second grant cycle of requester 3.
        v(0, 4'b1000, 4'b0000, 1, 0, 0, 8'h00, 0, 1);
        v(0, 4'b1000, 4'b1000, 3, 1, 1, 8'h3C, 0, 1);
        v(1, 4'b1000, 4'b1000, 3, 1, 1, 8'h3C, 0, 1);
        v(0, 4'b1000, 4'b0000, 0, 0, 0, 8'h00, 0, 1);
        v(0, 4'b1000, 4'b1000, 3, 1, 1, 8'h3C, 0, 1);
        v(0, 4'b0000, 4'b1000, 3, 1, 0, 8'h00, 0, 1);
        v(0, 4'b0000, 4'b0000, 3, 0, 0, 8'h00, 0, 1);

        repeat (2) @(posedge clk);
        foreach (vecs[i]) begin
            #1;
            reset = vecs[i].rst;
            req   = vecs[i].req;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
        end
        #1;
        reset = 1'b0;
        req   = 4'b0000;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected beats left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
